ram_arbiter: RTL and testbench
==============================

# ram_arbiter

Single-port RAM arbiter for the Spectrum core. It shares one synchronous 64 KB RAM port between three requesters: the video fetcher, the Z80 CPU and the tape/snapshot loader DMA. It sits between those requesters and the RAM. It also generates the CPU `wait_n` stall and write-protects the ROM region against CPU writes.

## Interface
Parameters:
- `STARVE_MAX`, default 8: consecutive denied loader cycles before the loader is promoted above the CPU.
- `CONT_LO`, default 16'h4000: lowest contended address.
- `CONT_HI`, default 16'h7FFF: highest contended address.

Ports:
- `clk`  in  1  system clock; the only clock.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `vid_req`  in  1  video read request.
- `vid_addr`  in  16  video read address.
- `vid_active`  in  1  video is inside the display fetch window.
- `vid_ack`  out  1  video request granted this cycle.
- `vid_rvalid`  out  1  video read data valid.
- `vid_rdata`  out  8  video read data.
- `cpu_req`  in  1  CPU access request.
- `cpu_we`  in  1  CPU access is a write.
- `cpu_addr`  in  16  CPU address.
- `cpu_wdata`  in  8  CPU write data.
- `cpu_ack`  out  1  CPU request granted this cycle.
- `cpu_rvalid`  out  1  CPU read data valid.
- `cpu_rdata`  out  8  CPU read data.
- `cpu_wait_n`  out  1  low while a CPU request is pending and not granted.
- `ld_req`  in  1  loader write request.
- `ld_addr`  in  16  loader address.
- `ld_wdata`  in  8  loader write data.
- `ld_ack`  out  1  loader request granted this cycle.
- `ram_addr`  out  16  RAM address.
- `ram_we`  out  1  RAM write enable.
- `ram_wdata`  out  8  RAM write data.
- `ram_din`  in  8  RAM read data, registered inside the RAM, one cycle latency.

## Operation
Request handshake:
- A requester holds `req` high with stable address and data until it sees `ack`.
- `ack` is a one-cycle pulse in the grant cycle.
- If `req` is still high in the cycle after `ack`, that is a new access.

Arbitration:
- Combinational, one grant per cycle.
- Default priority: video > CPU > loader.
- Promoted priority: video > loader > CPU. This applies while the starvation counter `starve` equals `STARVE_MAX`.
- Video is never delayed.

Starvation counter `starve`:
- Width is `$clog2(STARVE_MAX+1)`.
- Increments each cycle that `ld_req` is high and `ld_ack` is low.
- Saturates at `STARVE_MAX`.
- Clears to 0 on `ld_ack`, and when `ld_req` is low.

RAM port during a grant cycle:
- `ram_addr` is the granted requester's address.
- `ram_we` is 1 for a loader grant, and for a CPU write grant.
- `ram_wdata` is the granted requester's write data.

RAM port when no access is granted:
- `ram_we` is 0.
- `ram_addr` and `ram_wdata` are 0.

ROM protection:
- Applies to a CPU write with `cpu_addr[15:14]==0`.
- The write is acked normally but `ram_we` stays 0.
- The loader may write to any address.

Read return:
- A registered owner tag records which requester held each read grant: none, video or CPU.
- The cycle after the grant, the tagged requester's `rvalid` pulses for one cycle.
- Its `rdata` equals `ram_din` in that same cycle.
- `rdata` outputs hold their last value when `rvalid` is low.
- Writes produce no `rvalid`.

`cpu_wait_n = ~(cpu_req & ~cpu_ack)`, combinational.

## Timing
Reset values:
- All `ack` outputs, both `rvalid` outputs and `ram_we` are 0.
- `ram_addr` and `ram_wdata` are 0.
- `rdata` outputs are 0.
- `cpu_wait_n` is 1.
- `starve` is 0; the owner tag is none.

Latency:
- Grant occurs in the cycle the request is first visible, if it wins arbitration.
- Read data arrives one cycle after the grant.
- Back-to-back grants to any mix of requesters are allowed every cycle.

Reset asserted mid-access:
- The owner tag clears immediately, so a pending `rvalid` is never issued.
- After `reset_n` rises, the first grant may occur in the first cycle.

Simultaneous requests:
- Exactly one `ack` is high per cycle.
- A losing requester keeps `req` high and wins in a later cycle.

Worst-case loader wait with video idle is `STARVE_MAX+1` cycles.

## Configuration
`RAM_ARB_CONTENTION_EN`:
- Defined: a CPU request with `CONT_LO <= cpu_addr <= CONT_HI` is ineligible while `vid_active` is 1. `cpu_wait_n` stays low for that time. The loader may take the slot.
- Undefined: `vid_active` is ignored, and the CPU stalls only on arbitration loss.

## Test plan
- Reset, then a CPU read of 16'h8000 with `ram_din`=8'hA5 the following cycle: `cpu_ack` is high in cycle 0, and `cpu_rvalid` is high with `cpu_rdata`=8'hA5 in cycle 1.
- `vid_req` and `cpu_req` both high for 3 cycles, with CPU reading 16'hC000: `vid_ack` is high every cycle, `cpu_wait_n` is 0 for those 3 cycles, and `cpu_ack` arrives in cycle 3.
- `cpu_req` held continuously and `ld_req` high, with `STARVE_MAX`=8 and video idle: the CPU wins 8 cycles, then `ld_ack` is high in cycle 8 and `starve` returns to 0.
- CPU write 8'h55 to 16'h1234: `cpu_ack`=1 and `ram_we`=0. Loader write 8'h55 to 16'h1234: `ld_ack`=1, `ram_we`=1 and `ram_addr`=16'h1234.
- With `RAM_ARB_CONTENTION_EN`, `vid_active`=1 and a CPU read of 16'h5000: no `cpu_ack` until `vid_active` falls. A CPU read of 16'h9000 under the same conditions is acked immediately.
- Assert `reset_n` low in the cycle after a CPU read grant: `cpu_rvalid` stays 0, and all outputs take their reset values.

Source files
------------

// File: rtl/ram_arbiter.sv
// Arbiter that shares one synchronous RAM port between video, CPU and loader, with a loader anti-starvation promotion.
// Optional macro RAM_ARB_CONTENTION_EN: when defined, the CPU is held off contended memory while video is fetching.
module ram_arbiter #(
   parameter int unsigned STARVE_MAX = 8,
   parameter logic [15:0] CONT_LO    = 16'h4000,
   parameter logic [15:0] CONT_HI    = 16'h7FFF,
   localparam int SW = $clog2(STARVE_MAX + 1)
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          vid_req,
   input  logic [15:0]   vid_addr,
   input  logic          vid_active,
   output logic          vid_ack,
   output logic          vid_rvalid,
   output logic [7:0]    vid_rdata,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [15:0]   cpu_addr,
   input  logic [7:0]    cpu_wdata,
   output logic          cpu_ack,
   output logic          cpu_rvalid,
   output logic [7:0]    cpu_rdata,
   output logic          cpu_wait_n,
   input  logic          ld_req,
   input  logic [15:0]   ld_addr,
   input  logic [7:0]    ld_wdata,
   output logic          ld_ack,
   output logic [15:0]   ram_addr,
   output logic          ram_we,
   output logic [7:0]    ram_wdata,
   input  logic [7:0]    ram_din,
   output logic [SW-1:0] dbg_starve_o,
   output logic [1:0]    dbg_owner_o
);

   typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_VID = 2'd1, OWN_CPU = 2'd2} owner_e;

   owner_e        owner_q, owner_d;
   logic [SW-1:0] starve_q, starve_d;
   logic [7:0]    vid_rdata_q, cpu_rdata_q;

   logic vid_req_v, cpu_req_v, ld_req_v;
   logic cont_hit, cpu_stall, cpu_elig, promoted;
   logic grant_vid, grant_cpu, grant_ld;

   // Requests are masked in reset so every grant-derived output shows its reset value.
   assign vid_req_v = vid_req & reset_n;
   assign cpu_req_v = cpu_req & reset_n;
   assign ld_req_v  = ld_req & reset_n;

   assign cont_hit = (cpu_addr >= CONT_LO) && (cpu_addr <= CONT_HI);
`ifdef RAM_ARB_CONTENTION_EN
   assign cpu_stall = vid_active & cont_hit;
`else
   logic unused_cont;
   assign cpu_stall   = 1'b0;
   assign unused_cont = vid_active | cont_hit;
`endif

   assign cpu_elig  = cpu_req_v & ~cpu_stall;
   assign promoted  = (starve_q == SW'(STARVE_MAX));
   assign grant_vid = vid_req_v;
   assign grant_cpu = ~vid_req_v & cpu_elig & ~(promoted & ld_req_v);
   assign grant_ld  = ~vid_req_v & ld_req_v & (~cpu_elig | promoted);

   assign vid_ack    = grant_vid;
   assign cpu_ack    = grant_cpu;
   assign ld_ack     = grant_ld;
   assign cpu_wait_n = ~(cpu_req_v & ~grant_cpu);

   always_comb begin
      ram_addr  = 16'h0000;
      ram_we    = 1'b0;
      ram_wdata = 8'h00;
      owner_d   = OWN_NONE;
      if (grant_vid) begin
         ram_addr = vid_addr;
         owner_d  = OWN_VID;
      end else if (grant_cpu) begin
         ram_addr  = cpu_addr;
         ram_wdata = cpu_wdata;
         // ROM region: the write is acknowledged but silently dropped.
         ram_we    = cpu_we & (cpu_addr[15:14] != 2'b00);
         owner_d   = cpu_we ? OWN_NONE : OWN_CPU;
      end else if (grant_ld) begin
         ram_addr  = ld_addr;
         ram_wdata = ld_wdata;
         ram_we    = 1'b1;
      end
   end

   always_comb begin
      starve_d = '0;
      if (ld_req_v && !grant_ld)
         starve_d = promoted ? starve_q : starve_q + SW'(1);
   end

   assign vid_rvalid   = (owner_q == OWN_VID);
   assign cpu_rvalid   = (owner_q == OWN_CPU);
   assign vid_rdata    = vid_rvalid ? ram_din : vid_rdata_q;
   assign cpu_rdata    = cpu_rvalid ? ram_din : cpu_rdata_q;
   assign dbg_starve_o = starve_q;
   assign dbg_owner_o  = owner_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         owner_q     <= OWN_NONE;
         starve_q    <= '0;
         vid_rdata_q <= 8'h00;
         cpu_rdata_q <= 8'h00;
      end else begin
         owner_q  <= owner_d;
         starve_q <= starve_d;
         if (vid_rvalid) vid_rdata_q <= ram_din;
         if (cpu_rvalid) cpu_rdata_q <= ram_din;
      end
   end

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: stimulus pushes per-cycle expected port activity, a negedge monitor pops and compares.
module tb_ram_arbiter;

   typedef logic [42:0] ev_t;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        vid_req = 1'b0, vid_active = 1'b0;
   logic [15:0] vid_addr = 16'h0;
   logic        cpu_req = 1'b0, cpu_we = 1'b0;
   logic [15:0] cpu_addr = 16'h0;
   logic [7:0]  cpu_wdata = 8'h0;
   logic        ld_req = 1'b0;
   logic [15:0] ld_addr = 16'h0;
   logic [7:0]  ld_wdata = 8'h0;
   logic [7:0]  ram_din = 8'h0;
   logic        vid_ack, vid_rvalid, cpu_ack, cpu_rvalid, cpu_wait_n, ld_ack, ram_we;
   logic [7:0]  vid_rdata, cpu_rdata, ram_wdata;
   logic [15:0] ram_addr;
   logic [3:0]  dbg_starve;
   logic [1:0]  dbg_owner;

   int   checks = 0;
   int   failures = 0;
   ev_t  exp_q[$];

   ram_arbiter dut (
      .clk(clk), .reset_n(reset_n),
      .vid_req(vid_req), .vid_addr(vid_addr), .vid_active(vid_active),
      .vid_ack(vid_ack), .vid_rvalid(vid_rvalid), .vid_rdata(vid_rdata),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ack(cpu_ack), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .cpu_wait_n(cpu_wait_n),
      .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_ack(ld_ack),
      .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_din(ram_din),
      .dbg_starve_o(dbg_starve), .dbg_owner_o(dbg_owner)
   );

   // clock / reset
   always #5 clk = ~clk;

   // ack {vid,cpu,ld}, rvalid {vid,cpu}
   function automatic ev_t mk(input logic [2:0] ack, input logic [1:0] rv, input logic we,
                              input logic [15:0] a, input logic [7:0] wd, input logic [7:0] rd,
                              input logic wn, input logic [3:0] st);
      return {ack, rv, we, a, wd, rd, wn, st};
   endfunction

   task automatic chk(input string nm, input logic [47:0] got, input logic [47:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", nm, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input ev_t e);
      exp_q.push_back(e);
   endtask

   // monitor
   always @(negedge clk) begin
      ev_t obs, e;
      if (reset_n && (vid_ack || cpu_ack || ld_ack || vid_rvalid || cpu_rvalid || ram_we)) begin
         obs = {vid_ack, cpu_ack, ld_ack, vid_rvalid, cpu_rvalid, ram_we, ram_addr, ram_wdata,
                vid_rvalid ? vid_rdata : (cpu_rvalid ? cpu_rdata : 8'h00), cpu_wait_n, dbg_starve};
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_activity t=%0t got=%h exp=none", $time, obs);
         end else begin
            e = exp_q.pop_front();
            chk("port_event", {5'h0, obs}, {5'h0, e});
         end
      end
   end

   initial begin
      reset_n = 1'b0;
      @(negedge clk);
      chk("rst_acks", {vid_ack, cpu_ack, ld_ack}, 3'b000);
      chk("rst_rvalid", {vid_rvalid, cpu_rvalid}, 2'b00);
      chk("rst_ram", {ram_we, ram_addr, ram_wdata}, 25'h0);
      chk("rst_rdata", {vid_rdata, cpu_rdata}, 16'h0);
      chk("rst_wait_n", cpu_wait_n, 1'b1);
      chk("rst_state", {dbg_starve, dbg_owner}, 6'h0);
      step();
      reset_n = 1'b1;
      step();

      // CPU read of 8000, data one cycle later
      cpu_req = 1'b1; cpu_addr = 16'h8000;
      push(mk(3'b010, 2'b00, 1'b0, 16'h8000, 8'h00, 8'h00, 1'b1, 4'd0));
      step();
      cpu_req = 1'b0; ram_din = 8'hA5;
      push(mk(3'b000, 2'b01, 1'b0, 16'h0000, 8'h00, 8'hA5, 1'b1, 4'd0));
      step();
      ram_din = 8'h00;
      step();

      // video beats CPU for 3 cycles
      vid_req = 1'b1; cpu_req = 1'b1; cpu_addr = 16'hC000;
      for (int k = 0; k < 3; k++) begin
         vid_addr = 16'h4000 + 16'(k);
         ram_din  = 8'(8'h11 * k);
         push(mk(3'b100, (k == 0) ? 2'b00 : 2'b10, 1'b0, vid_addr, 8'h00, ram_din, 1'b0, 4'd0));
         step();
      end
      vid_req = 1'b0; ram_din = 8'h33;
      push(mk(3'b010, 2'b10, 1'b0, 16'hC000, 8'h00, 8'h33, 1'b1, 4'd0));
      step();
      cpu_req = 1'b0; ram_din = 8'h44;
      push(mk(3'b000, 2'b01, 1'b0, 16'h0000, 8'h00, 8'h44, 1'b1, 4'd0));
      step();
      ram_din = 8'h00;
      step();

      // loader starvation and promotion
      cpu_req = 1'b1; cpu_addr = 16'h8100;
      ld_req = 1'b1; ld_addr = 16'h9000; ld_wdata = 8'h77;
      for (int k = 0; k < 8; k++) begin
         ram_din = 8'(8'h60 + k);
         push(mk(3'b010, (k == 0) ? 2'b00 : 2'b01, 1'b0, 16'h8100, 8'h00,
                 (k == 0) ? 8'h00 : ram_din, 1'b1, 4'(k)));
         step();
      end
      ram_din = 8'h68;
      push(mk(3'b001, 2'b01, 1'b1, 16'h9000, 8'h77, 8'h68, 1'b0, 4'd8));
      step();
      ld_req = 1'b0; ram_din = 8'h00;
      push(mk(3'b010, 2'b00, 1'b0, 16'h8100, 8'h00, 8'h00, 1'b1, 4'd0));
      step();
      cpu_req = 1'b0; ram_din = 8'h69;
      push(mk(3'b000, 2'b01, 1'b0, 16'h0000, 8'h00, 8'h69, 1'b1, 4'd0));
      step();
      ram_din = 8'h00;

      // ROM protection
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h1234; cpu_wdata = 8'h55;
      push(mk(3'b010, 2'b00, 1'b0, 16'h1234, 8'h55, 8'h00, 1'b1, 4'd0));
      step();
      cpu_req = 1'b0; ld_req = 1'b1; ld_addr = 16'h1234; ld_wdata = 8'h55;
      push(mk(3'b001, 2'b00, 1'b1, 16'h1234, 8'h55, 8'h00, 1'b1, 4'd0));
      step();
      ld_req = 1'b0; cpu_req = 1'b1; cpu_addr = 16'h8000; cpu_wdata = 8'hA5;
      push(mk(3'b010, 2'b00, 1'b1, 16'h8000, 8'hA5, 8'h00, 1'b1, 4'd0));
      step();
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_wdata = 8'h00;
      step();

      // contended memory
      vid_active = 1'b1; cpu_req = 1'b1; cpu_addr = 16'h5000;
`ifdef RAM_ARB_CONTENTION_EN
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("cont_stall_ack", cpu_ack, 1'b0);
         chk("cont_stall_wait_n", cpu_wait_n, 1'b0);
         step();
      end
      ld_req = 1'b1; ld_addr = 16'h2000; ld_wdata = 8'h99;
      push(mk(3'b001, 2'b00, 1'b1, 16'h2000, 8'h99, 8'h00, 1'b0, 4'd0));
      step();
      ld_req = 1'b0; vid_active = 1'b0;
`endif
      push(mk(3'b010, 2'b00, 1'b0, 16'h5000, 8'h00, 8'h00, 1'b1, 4'd0));
      step();
      cpu_req = 1'b0; ram_din = 8'hBB;
      push(mk(3'b000, 2'b01, 1'b0, 16'h0000, 8'h00, 8'hBB, 1'b1, 4'd0));
      step();
      vid_active = 1'b1; cpu_req = 1'b1; cpu_addr = 16'h9000; ram_din = 8'h00;
      push(mk(3'b010, 2'b00, 1'b0, 16'h9000, 8'h00, 8'h00, 1'b1, 4'd0));
      step();
      cpu_req = 1'b0; ram_din = 8'hCC;
      push(mk(3'b000, 2'b01, 1'b0, 16'h0000, 8'h00, 8'hCC, 1'b1, 4'd0));
      step();
      vid_active = 1'b0; ram_din = 8'h00;
      step();

      // reset right after a CPU read grant
      cpu_req = 1'b1; cpu_addr = 16'h8000;
      push(mk(3'b010, 2'b00, 1'b0, 16'h8000, 8'h00, 8'h00, 1'b1, 4'd0));
      step();
      reset_n = 1'b0; cpu_req = 1'b0; ram_din = 8'hEE;
      @(negedge clk);
      chk("midrst_rvalid", {vid_rvalid, cpu_rvalid}, 2'b00);
      chk("midrst_rdata", {vid_rdata, cpu_rdata}, 16'h0);
      chk("midrst_ram", {ram_we, ram_addr, ram_wdata}, 25'h0);
      chk("midrst_misc", {vid_ack, cpu_ack, ld_ack, cpu_wait_n, dbg_starve, dbg_owner}, 10'b0001_0000_00);
      step();
      reset_n = 1'b1; ram_din = 8'h00; cpu_req = 1'b1; cpu_addr = 16'h8200;
      push(mk(3'b010, 2'b00, 1'b0, 16'h8200, 8'h00, 8'h00, 1'b1, 4'd0));
      step();
      cpu_req = 1'b0; ram_din = 8'h5A;
      push(mk(3'b000, 2'b01, 1'b0, 16'h0000, 8'h00, 8'h5A, 1'b1, 4'd0));
      step();
      ram_din = 8'h00;
      step();
      step();

      chk("queue_drained", 48'(exp_q.size()), 48'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
